// File: rtl/load_store_unit.sv
// load_store_unit: data-memory initiator issuing word-aligned bus accesses with byte lanes, load formatting and timeout.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of silently aligning them.
module load_store_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lsu_req,
    input  logic                  lsu_we,
    input  logic [2:0]            lsu_funct3,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    output logic                  lsu_busy,
    output logic                  lsu_done,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic                  lsu_fault,
    output logic                  lsu_misaligned,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [3:0]            bus_be,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_gnt,
    input  logic                  bus_rvalid,
    input  logic [DATA_WIDTH-1:0] bus_rdata
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e                state_q, state_d;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [1:0]            off_q, off_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d, fmt;
    logic                  fault_q, fault_d;
    logic                  bus_req_q, bus_req_d, bus_we_q;
    logic [3:0]            bus_be_q, be_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q;
    logic [DATA_WIDTH-1:0] bus_wdata_q, wdata_d;
    logic                  accept, illegal, trap, skip, timeout, complete, expire;
    logic [7:0]            sel_b;
    logic [15:0]           sel_h;

    assign accept  = state_q == IDLE && lsu_req;
    assign illegal = lsu_funct3 == 3'b011 || lsu_funct3[2:1] == 2'b11 || (lsu_we && lsu_funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q, mis_d;
    assign trap  = !illegal && ((lsu_funct3[1:0] == 2'b01 && lsu_addr[0]) ||
                                (lsu_funct3[1:0] == 2'b10 && lsu_addr[1:0] != 2'b00));
    assign off_d = lsu_addr[1:0];
    assign mis_d = accept && trap;
    assign lsu_misaligned = mis_q;
`else
    // Without trapping, the offending low address bits are dropped and the access proceeds aligned.
    assign trap  = 1'b0;
    assign off_d = lsu_funct3[1:0] == 2'b01 ? {lsu_addr[1], 1'b0} :
                   lsu_funct3[1:0] == 2'b10 ? 2'b00 : lsu_addr[1:0];
    assign lsu_misaligned = 1'b0;
`endif
    assign skip     = illegal || trap;
    assign timeout  = cnt_q == CW'(TIMEOUT_CYCLES - 1);
    assign complete = (state_q == REQ && bus_gnt && (we_q || bus_rvalid)) || (state_q == WAIT && bus_rvalid);
    // A response in the final allowed cycle still wins over the timeout.
    assign expire   = (state_q == REQ || state_q == WAIT) && timeout && !complete;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = !lsu_req ? IDLE : skip ? DONE : REQ;
            REQ:     state_d = (complete || expire) ? DONE : bus_gnt ? WAIT : REQ;
            WAIT:    state_d = (complete || expire) ? DONE : WAIT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lsu_busy = accept || state_q == REQ || state_q == WAIT;
        lsu_done = state_q == DONE;
    end

    always_comb begin
        sel_b     = bus_rdata[{off_q, 3'b000} +: 8];
        sel_h     = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        fmt       = f3_q[1:0] == 2'b00 ? {{24{sel_b[7] & ~f3_q[2]}}, sel_b} :
                    f3_q[1:0] == 2'b01 ? {{16{sel_h[15] & ~f3_q[2]}}, sel_h} : bus_rdata;
        rdata_d   = (complete && !we_q) ? fmt : expire ? '0 : rdata_q;
        cnt_d     = (state_q == REQ || state_q == WAIT) ? cnt_q + CW'(1) : '0;
        fault_d   = (accept && illegal) || expire;
        bus_req_d = state_d == REQ;
        be_d      = !lsu_we ? 4'b1111 :
                    lsu_funct3[1:0] == 2'b00 ? 4'b0001 << off_d :
                    lsu_funct3[1:0] == 2'b01 ? 4'b0011 << off_d : 4'b1111;
        wdata_d   = lsu_funct3[1:0] == 2'b00 ? {4{lsu_wdata[7:0]}} :
                    lsu_funct3[1:0] == 2'b01 ? {2{lsu_wdata[15:0]}} : lsu_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q        <= 1'b0;
            f3_q        <= '0;
            off_q       <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            fault_q     <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            fault_q   <= fault_d;
            bus_req_q <= bus_req_d;
            if (accept && !skip) begin
                we_q        <= lsu_we;
                f3_q        <= lsu_funct3;
                off_q       <= off_d;
                bus_we_q    <= lsu_we;
                bus_be_q    <= be_d;
                bus_addr_q  <= {lsu_addr[ADDR_WIDTH-1:2], 2'b00};
                bus_wdata_q <= wdata_d;
            end
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) mis_q <= 1'b0;
        else       mis_q <= mis_d;
    end
`endif

    assign lsu_rdata = rdata_q;
    assign lsu_fault = fault_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_be    = bus_be_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit against a transaction-level model.
module tb_load_store_unit;
    localparam int TO = 12;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b1;
    logic        lsu_req = 1'b0, lsu_we = 1'b0;
    logic [2:0]  lsu_funct3 = '0;
    logic [31:0] lsu_addr = '0, lsu_wdata = '0;
    logic        lsu_busy, lsu_done, lsu_fault, lsu_misaligned;
    logic [31:0] lsu_rdata;
    logic        bus_req, bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;

    int errors = 0, checks = 0;
    logic [31:0] model_rdata = '0;

    int          o_done_cyc, o_req_cycles;
    logic        o_busy0, o_busy_ok, o_stable, o_we, o_fault, o_mis;
    logic [31:0] o_addr, o_wdata, o_rdata;
    logic [3:0]  o_be;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_fault(lsu_fault),
        .lsu_misaligned(lsu_misaligned),
        .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    function automatic bit is_illegal(input logic we, input logic [2:0] f3);
        return f3 == 3 || f3 == 6 || f3 == 7 || (we && f3 >= 4);
    endfunction

    function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] a);
        return ((f3 % 4) == 1 && (a % 2) == 1) || ((f3 % 4) == 2 && (a % 4) != 0);
    endfunction

    function automatic int eff_off(input logic [2:0] f3, input logic [31:0] a);
        if (TRAP || (f3 % 4) == 0) return int'(a % 4);
        if ((f3 % 4) == 1) return int'(a % 4) / 2 * 2;
        return 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
        if (!we || (f3 % 4) == 2) return 4'hF;
        return ((f3 % 4) == 0 ? 4'd1 : 4'd3) << eff_off(f3, a);
    endfunction

    function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] w);
        if ((f3 % 4) == 0) return (w & 32'hFF) * 32'h0101_0101;
        if ((f3 % 4) == 1) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] raw);
        logic [31:0] v;
        v = raw >> (8 * eff_off(f3, a));
        if ((f3 % 4) == 0) begin
            v = v & 32'hFF;
            if (f3 == 0 && v >= 128) v = v | 32'hFFFF_FF00;
        end else if ((f3 % 4) == 1) begin
            v = v & 32'hFFFF;
            if (f3 == 1 && v >= 32768) v = v | 32'hFFFF_0000;
        end else v = raw;
        return v;
    endfunction

    // Drives one request and acts as the memory: gnt after g REQ cycles, rvalid r cycles after gnt.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] raw, input int g, input int r);
        int cyc, nreq, gcyc;
        bit done;
        lsu_req = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wd; bus_rdata = raw;
        #1 o_busy0 = lsu_busy;
        @(posedge clk); #1;
        lsu_req = 1'b0; lsu_we = 1'($urandom); lsu_funct3 = 3'($urandom); lsu_addr = $urandom; lsu_wdata = $urandom;
        cyc = 1; nreq = 0; gcyc = -1; done = 0;
        o_req_cycles = 0; o_busy_ok = 1'b1; o_stable = 1'b1; o_done_cyc = -1;
        while (!done && cyc < TO + 8) begin
            if (lsu_done) begin
                done = 1; o_done_cyc = cyc; o_fault = lsu_fault; o_mis = lsu_misaligned; o_rdata = lsu_rdata;
                if (lsu_busy) o_busy_ok = 1'b0;
            end else begin
                if (!lsu_busy) o_busy_ok = 1'b0;
                if (bus_req) begin
                    if (nreq == 0) begin
                        o_addr = bus_addr; o_we = bus_we; o_be = bus_be; o_wdata = bus_wdata;
                    end else if ({bus_addr, bus_we, bus_be, bus_wdata} !== {o_addr, o_we, o_be, o_wdata}) o_stable = 1'b0;
                    o_req_cycles++;
                end
                bus_gnt = bus_req && nreq == g;
                if (bus_gnt) gcyc = cyc;
                if (bus_req) nreq++;
                bus_rvalid = !we && gcyc >= 0 && cyc == gcyc + r;
                @(posedge clk); #1;
                cyc++;
            end
        end
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata} !== '0) begin
            errors++; $display("FAIL reset_bus got req=%b we=%b be=%h addr=%h wd=%h exp all 0", bus_req, bus_we, bus_be, bus_addr, bus_wdata);
        end
        checks++;
        if ({lsu_busy, lsu_done, lsu_fault, lsu_misaligned, lsu_rdata} !== '0) begin
            errors++; $display("FAIL reset_lsu got busy=%b done=%b fault=%b mis=%b rdata=%h exp all 0", lsu_busy, lsu_done, lsu_fault, lsu_misaligned, lsu_rdata);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_store_word();
        run_txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
        checks++; if (o_addr !== 32'h10) begin errors++; $display("FAIL sw_addr got %h exp 00000010", o_addr); end
        checks++; if ({o_we, o_be} !== 5'b1_1111) begin errors++; $display("FAIL sw_we_be got we=%b be=%b exp 1 1111", o_we, o_be); end
        checks++; if (o_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got %h exp deadbeef", o_wdata); end
        checks++; if (o_done_cyc !== 2) begin errors++; $display("FAIL sw_latency got %0d exp 2", o_done_cyc); end
        checks++; if (o_busy0 !== 1'b1 || o_busy_ok !== 1'b1) begin errors++; $display("FAIL sw_busy got acc=%b window_ok=%b exp 1 1", o_busy0, o_busy_ok); end
    endtask

    task automatic test_load_byte();
        run_txn(1'b0, 3'b000, 32'h13, 32'h0, 32'h80112233, 0, 2);
        checks++; if (o_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata got %h exp ffffff80", o_rdata); end
        checks++; if (o_done_cyc !== 4) begin errors++; $display("FAIL lb_latency got %0d exp 4", o_done_cyc); end
        checks++; if ({o_we, o_be, o_addr} !== {1'b0, 4'hF, 32'h10}) begin errors++; $display("FAIL lb_bus got we=%b be=%h addr=%h exp 0 f 00000010", o_we, o_be, o_addr); end
        run_txn(1'b0, 3'b100, 32'h13, 32'h0, 32'h80112233, 0, 1);
        checks++; if (o_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu_rdata got %h exp 00000080", o_rdata); end
        checks++; if (o_done_cyc !== 3) begin errors++; $display("FAIL lbu_latency got %0d exp 3", o_done_cyc); end
    endtask

    task automatic test_half();
        run_txn(1'b1, 3'b001, 32'h22, 32'h0000ABCD, 32'h0, 1, 0);
        checks++; if (o_be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b exp 1100", o_be); end
        checks++; if (o_wdata !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata got %h exp abcdabcd", o_wdata); end
        checks++; if (o_done_cyc !== 3 || o_stable !== 1'b1) begin errors++; $display("FAIL sh_hold got done=%0d stable=%b exp 3 1", o_done_cyc, o_stable); end
        run_txn(1'b0, 3'b001, 32'h22, 32'h0, 32'h7FFF0000, 0, 1);
        checks++; if (o_rdata !== 32'h00007FFF) begin errors++; $display("FAIL lh_rdata got %h exp 00007fff", o_rdata); end
    endtask

    task automatic test_same_cycle();
        run_txn(1'b0, 3'b010, 32'h04, 32'h0, 32'h12345678, 0, 0);
        checks++; if (o_done_cyc !== 2) begin errors++; $display("FAIL lw_same_latency got %0d exp 2", o_done_cyc); end
        checks++; if (o_rdata !== 32'h12345678) begin errors++; $display("FAIL lw_same_rdata got %h exp 12345678", o_rdata); end
        model_rdata = 32'h12345678;
    endtask

    task automatic test_illegal();
        run_txn(1'b0, 3'b011, 32'h40, 32'h0, 32'h5555AAAA, 0, 0);
        checks++; if (o_req_cycles !== 0) begin errors++; $display("FAIL ill_noreq got %0d req cycles exp 0", o_req_cycles); end
        checks++; if ({o_done_cyc == 1, o_fault, o_mis} !== 3'b110) begin errors++; $display("FAIL ill_done got cyc=%0d fault=%b mis=%b exp 1 1 0", o_done_cyc, o_fault, o_mis); end
        checks++; if (o_rdata !== 32'h12345678) begin errors++; $display("FAIL ill_rdata got %h exp 12345678", o_rdata); end
        run_txn(1'b1, 3'b100, 32'h40, 32'h0, 32'h0, 0, 0);
        checks++; if (o_req_cycles !== 0 || o_fault !== 1'b1) begin errors++; $display("FAIL ill_store got req=%0d fault=%b exp 0 1", o_req_cycles, o_fault); end
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 3'b010, 32'h80, 32'h0, 32'hFFFFFFFF, TO + 20, 0);
        checks++; if (o_req_cycles !== TO) begin errors++; $display("FAIL to_req_cycles got %0d exp %0d", o_req_cycles, TO); end
        checks++; if (o_done_cyc !== TO + 1 || o_fault !== 1'b1) begin errors++; $display("FAIL to_done got cyc=%0d fault=%b exp %0d 1", o_done_cyc, o_fault, TO + 1); end
        checks++; if (o_rdata !== 32'h0) begin errors++; $display("FAIL to_rdata got %h exp 00000000", o_rdata); end
        model_rdata = '0;
    endtask

    task automatic test_misaligned();
        run_txn(1'b0, 3'b010, 32'h05, 32'h0, 32'hA5A5_0F0F, 0, 0);
        if (TRAP) begin
            checks++; if ({o_req_cycles == 0, o_mis, o_fault} !== 3'b110) begin errors++; $display("FAIL mis_trap got req=%0d mis=%b fault=%b exp 0 1 0", o_req_cycles, o_mis, o_fault); end
            checks++; if (o_done_cyc !== 1 || o_rdata !== model_rdata) begin errors++; $display("FAIL mis_trap_done got cyc=%0d rdata=%h exp 1 %h", o_done_cyc, o_rdata, model_rdata); end
        end else begin
            checks++; if (o_addr !== 32'h04 || o_mis !== 1'b0) begin errors++; $display("FAIL mis_align got addr=%h mis=%b exp 00000004 0", o_addr, o_mis); end
            checks++; if (o_done_cyc !== 2 || o_rdata !== 32'hA5A5_0F0F) begin errors++; $display("FAIL mis_align_done got cyc=%0d rdata=%h exp 2 a5a50f0f", o_done_cyc, o_rdata); end
            model_rdata = 32'hA5A5_0F0F;
        end
    endtask

    task automatic test_random(input int n);
        logic we; logic [2:0] f3; logic [31:0] addr, wd, raw, erd;
        int g, r, sel, resp, edone, ereq; bit ill, trp, ef;
        for (int i = 0; i < n; i++) begin
            sel = $urandom_range(0, 19);
            we = 1'($urandom);
            f3 = sel == 3 ? 3'($urandom) : (sel % 5 == 4 ? 3'd4 : 3'($urandom_range(0, 2)));
            if (sel == 5) f3 = 3'd5;
            addr = $urandom; wd = $urandom; raw = $urandom;
            g = sel == 0 ? TO + 3 : sel == 1 ? TO - 1 : $urandom_range(0, 3);
            r = sel == 2 ? TO : $urandom_range(0, 3);
            run_txn(we, f3, addr, wd, raw, g, r);
            ill = is_illegal(we, f3);
            trp = TRAP && !ill && is_mis(f3, addr);
            resp = g + 1 + (we ? 0 : r);
            if (ill || trp) begin edone = 1; ereq = 0; ef = ill; erd = model_rdata; end
            else if (resp <= TO) begin edone = resp + 1; ereq = g + 1; ef = 0; erd = we ? model_rdata : exp_load(f3, addr, raw); end
            else begin edone = TO + 1; ereq = (g + 1 <= TO) ? g + 1 : TO; ef = 1; erd = '0; end
            checks++; if (o_done_cyc !== edone) begin errors++; $display("FAIL rnd%0d done_cyc got %0d exp %0d", i, o_done_cyc, edone); end
            checks++; if (o_req_cycles !== ereq) begin errors++; $display("FAIL rnd%0d req_cycles got %0d exp %0d", i, o_req_cycles, ereq); end
            checks++; if ({o_fault, o_mis} !== {ef, trp}) begin errors++; $display("FAIL rnd%0d fault_mis got %b%b exp %b%b", i, o_fault, o_mis, ef, trp); end
            checks++; if (o_rdata !== erd) begin errors++; $display("FAIL rnd%0d rdata got %h exp %h", i, o_rdata, erd); end
            checks++; if ({o_busy0, o_busy_ok} !== 2'b11) begin errors++; $display("FAIL rnd%0d busy got acc=%b window_ok=%b exp 1 1", i, o_busy0, o_busy_ok); end
            if (ereq > 0) begin
                checks++;
                if ({o_addr, o_we, o_be, o_wdata, o_stable} !== {addr & ~32'h3, we, exp_be(we, f3, addr), we ? exp_wd(f3, wd) : o_wdata, 1'b1}) begin
                    errors++; $display("FAIL rnd%0d bus got addr=%h we=%b be=%b wd=%h stable=%b exp %h %b %b %h 1", i, o_addr, o_we, o_be, o_wdata, o_stable,
                                       addr & ~32'h3, we, exp_be(we, f3, addr), exp_wd(f3, wd));
                end
            end
            model_rdata = erd;
        end
    endtask

    task automatic test_reset_mid();
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h100; bus_rdata = 32'hCAFEF00D;
        @(posedge clk); #1 lsu_req = 1'b0;
        reset = 1'b1; #1;
        checks++; if ({bus_req, lsu_busy} !== 2'b00) begin errors++; $display("FAIL rst_req got req=%b busy=%b exp 0 0", bus_req, lsu_busy); end
        @(posedge clk); #1 reset = 1'b0;
        lsu_req = 1'b1;
        @(posedge clk); #1 lsu_req = 1'b0; bus_gnt = 1'b1;
        @(posedge clk); #1 bus_gnt = 1'b0;
        reset = 1'b1; #1;
        checks++; if ({bus_req, lsu_busy, lsu_rdata} !== '0) begin errors++; $display("FAIL rst_wait got req=%b busy=%b rdata=%h exp 0 0 0", bus_req, lsu_busy, lsu_rdata); end
        @(posedge clk); #1 reset = 1'b0; bus_rvalid = 1'b1;
        @(posedge clk); #1 bus_rvalid = 1'b0;
        checks++; if ({lsu_done, lsu_busy, lsu_rdata} !== '0) begin errors++; $display("FAIL rst_rvalid got done=%b busy=%b rdata=%h exp 0 0 0", lsu_done, lsu_busy, lsu_rdata); end
        @(posedge clk); #1;
        checks++; if ({lsu_done, bus_req, lsu_rdata} !== '0) begin errors++; $display("FAIL rst_idle got done=%b req=%b rdata=%h exp 0 0 0", lsu_done, bus_req, lsu_rdata); end
        model_rdata = '0;
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_byte();
        test_half();
        test_same_cycle();
        test_illegal();
        test_timeout();
        test_misaligned();
        test_random(150);
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
